// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter
//
// Shares one single-port unified memory between the instruction-fetch path
// and the load/store path of the 16-bit MIPS core. The winner of arbitration
// gets one fixed-latency memory access. It then receives read data, or an
// ack for a store.
//
// When both ports request in the same cycle, the data port wins. The
// exception is a fetch that has already lost STARVE_LIMIT times in a row
// while waiting: in that case the fetch wins.
//
// Ports
//   clk, rst                     rising-edge clock, synchronous active-high reset
//   ifetch_req/addr              fetch request; held until ifetch_gnt
//   ifetch_gnt/valid/rdata       1-cycle accept pulse, 1-cycle data pulse, held data
//   data_req/we/addr/wdata       load/store request; held until data_gnt
//   data_gnt/valid/rdata         1-cycle accept pulse, 1-cycle done pulse, held load data
//   mem_en/we/addr/wdata         registered memory command
//   mem_rdata                    memory read data, sampled on the last access cycle
//   busy                         high whenever an access is in progress or completing
//
// Sequencing
//   IDLE/DONE --any req--> ACCESS (MEM_LATENCY cycles of mem_en) --> DONE (valid pulse)
module mips_mem_arbiter #(
    parameter int BUS_WIDTH    = 16,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ifetch_req,
    input  logic [BUS_WIDTH-1:0] ifetch_addr,
    output logic                 ifetch_gnt,
    output logic                 ifetch_valid,
    output logic [BUS_WIDTH-1:0] ifetch_rdata,
    input  logic                 data_req,
    input  logic                 data_we,
    input  logic [BUS_WIDTH-1:0] data_addr,
    input  logic [BUS_WIDTH-1:0] data_wdata,
    output logic                 data_gnt,
    output logic                 data_valid,
    output logic [BUS_WIDTH-1:0] data_rdata,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [BUS_WIDTH-1:0] mem_addr,
    output logic [BUS_WIDTH-1:0] mem_wdata,
    input  logic [BUS_WIDTH-1:0] mem_rdata,
    output logic                 busy
);

    localparam int LAT_W    = (MEM_LATENCY  > 1) ? $clog2(MEM_LATENCY)      : 1;
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [LAT_W-1:0]    LAT_LAST   = LAT_W'(MEM_LATENCY - 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                 state_reg;
    logic [LAT_W-1:0]       lat_cnt_reg;
    logic [STARVE_W-1:0]    starve_cnt_reg;
    logic                   win_data_reg;
    logic                   ifetch_gnt_reg;
    logic                   ifetch_valid_reg;
    logic [BUS_WIDTH-1:0]   ifetch_rdata_reg;
    logic                   data_gnt_reg;
    logic                   data_valid_reg;
    logic [BUS_WIDTH-1:0]   data_rdata_reg;
    logic                   mem_en_reg;
    logic                   mem_we_reg;
    logic [BUS_WIDTH-1:0]   mem_addr_reg;
    logic [BUS_WIDTH-1:0]   mem_wdata_reg;

    // Arbitration. Data wins by default. A fetch that has been starved
    // STARVE_LIMIT times takes the slot instead.
    logic any_req;
    logic fetch_starved;
    logic pick_data;

    assign any_req       = ifetch_req | data_req;
    assign fetch_starved = ifetch_req && (starve_cnt_reg == STARVE_MAX);
    assign pick_data     = data_req && !fetch_starved;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            lat_cnt_reg      <= '0;
            starve_cnt_reg   <= '0;
            win_data_reg     <= 1'b0;
            ifetch_gnt_reg   <= 1'b0;
            ifetch_valid_reg <= 1'b0;
            ifetch_rdata_reg <= '0;
            data_gnt_reg     <= 1'b0;
            data_valid_reg   <= 1'b0;
            data_rdata_reg   <= '0;
            mem_en_reg       <= 1'b0;
            mem_we_reg       <= 1'b0;
            mem_addr_reg     <= '0;
            mem_wdata_reg    <= '0;
        end else begin
            // Grant and valid are single-cycle pulses.
            ifetch_gnt_reg   <= 1'b0;
            data_gnt_reg     <= 1'b0;
            ifetch_valid_reg <= 1'b0;
            data_valid_reg   <= 1'b0;

            case (state_reg)
                IDLE, DONE: begin
                    if (any_req) begin
                        state_reg    <= ACCESS;
                        lat_cnt_reg  <= '0;
                        mem_en_reg   <= 1'b1;
                        win_data_reg <= pick_data;
                        if (pick_data) begin
                            data_gnt_reg  <= 1'b1;
                            mem_we_reg    <= data_we;
                            mem_addr_reg  <= data_addr;
                            mem_wdata_reg <= data_wdata;
                            // Count a lost slot only when fetch was actually waiting.
                            if (ifetch_req && (starve_cnt_reg != STARVE_MAX))
                                starve_cnt_reg <= starve_cnt_reg + STARVE_W'(1);
                        end else begin
                            ifetch_gnt_reg <= 1'b1;
                            mem_we_reg     <= 1'b0;
                            mem_addr_reg   <= ifetch_addr;
                            starve_cnt_reg <= '0;
                        end
                    end else begin
                        state_reg <= IDLE;
                    end
                end

                ACCESS: begin
                    if (lat_cnt_reg == LAT_LAST) begin
                        state_reg  <= DONE;
                        mem_en_reg <= 1'b0;
                        mem_we_reg <= 1'b0;
                        if (win_data_reg) begin
                            data_valid_reg <= 1'b1;
                            // A store leaves the previous load data in place.
                            if (!mem_we_reg)
                                data_rdata_reg <= mem_rdata;
                        end else begin
                            ifetch_valid_reg <= 1'b1;
                            ifetch_rdata_reg <= mem_rdata;
                        end
                    end else begin
                        lat_cnt_reg <= lat_cnt_reg + LAT_W'(1);
                    end
                end

                default: begin
                    state_reg  <= IDLE;
                    mem_en_reg <= 1'b0;
                    mem_we_reg <= 1'b0;
                end
            endcase
        end
    end

    assign ifetch_gnt   = ifetch_gnt_reg;
    assign ifetch_valid = ifetch_valid_reg;
    assign ifetch_rdata = ifetch_rdata_reg;
    assign data_gnt     = data_gnt_reg;
    assign data_valid   = data_valid_reg;
    assign data_rdata   = data_rdata_reg;
    assign mem_en       = mem_en_reg;
    assign mem_we       = mem_we_reg;
    assign mem_addr     = mem_addr_reg;
    assign mem_wdata    = mem_wdata_reg;
    assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_mips_mem_arbiter.sv
module tb_mips_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    // Main DUT: MEM_LATENCY=2, STARVE_LIMIT=3
    logic        ifetch_req, ifetch_gnt, ifetch_valid;
    logic [15:0] ifetch_addr, ifetch_rdata;
    logic        data_req, data_we, data_gnt, data_valid;
    logic [15:0] data_addr, data_wdata, data_rdata;
    logic        mem_en, mem_we, busy;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    // Second DUT: MEM_LATENCY=1, fetch-only stimulus
    logic        f1_req, f1_gnt, f1_valid;
    logic [15:0] f1_addr, f1_rdata;
    logic        d1_req, d1_we, d1_gnt, d1_valid;
    logic [15:0] d1_addr, d1_wdata, d1_rdata;
    logic        mem1_en, mem1_we, busy1;
    logic [15:0] mem1_addr, mem1_wdata, mem1_rdata;

    mips_mem_arbiter #(.BUS_WIDTH(16), .MEM_LATENCY(2), .STARVE_LIMIT(3)) dut (
        .clk(clk), .rst(rst),
        .ifetch_req(ifetch_req), .ifetch_addr(ifetch_addr), .ifetch_gnt(ifetch_gnt),
        .ifetch_valid(ifetch_valid), .ifetch_rdata(ifetch_rdata),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_gnt(data_gnt), .data_valid(data_valid),
        .data_rdata(data_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    mips_mem_arbiter #(.BUS_WIDTH(16), .MEM_LATENCY(1), .STARVE_LIMIT(3)) dut1 (
        .clk(clk), .rst(rst),
        .ifetch_req(f1_req), .ifetch_addr(f1_addr), .ifetch_gnt(f1_gnt),
        .ifetch_valid(f1_valid), .ifetch_rdata(f1_rdata),
        .data_req(d1_req), .data_we(d1_we), .data_addr(d1_addr),
        .data_wdata(d1_wdata), .data_gnt(d1_gnt), .data_valid(d1_valid),
        .data_rdata(d1_rdata),
        .mem_en(mem1_en), .mem_we(mem1_we), .mem_addr(mem1_addr),
        .mem_wdata(mem1_wdata), .mem_rdata(mem1_rdata), .busy(busy1)
    );

    // Simple memory shared by both DUTs (only the main DUT writes).
    logic [15:0] mem [256];
    assign mem_rdata  = mem[mem_addr[7:0]];
    assign mem1_rdata = mem[mem1_addr[7:0]];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
            mem[8'h10] <= 16'h1234;
            mem[8'h20] <= 16'h5A5A;
        end else if (mem_en && mem_we) begin
            mem[mem_addr[7:0]] <= mem_wdata;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        is_data;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs [7];
    logic [15:0] exp_i;   // expected held ifetch_rdata
    logic [15:0] exp_d;   // expected held data_rdata

    // One isolated transaction with MEM_LATENCY=2 timing.
    task automatic run_vec(input int idx, input vec_t v);
        @(negedge clk);
        if (v.is_data) begin
            data_req = 1'b1; data_we = v.we; data_addr = v.addr; data_wdata = v.wdata;
        end else begin
            ifetch_req = 1'b1; ifetch_addr = v.addr;
        end
        @(negedge clk);  // first ACCESS cycle
        check1("gnt_data", data_gnt, v.is_data);
        check1("gnt_fetch", ifetch_gnt, !v.is_data);
        check1("mem_en_c1", mem_en, 1'b1);
        check1("mem_we_c1", mem_we, v.is_data & v.we);
        check16("mem_addr", mem_addr, v.addr);
        if (v.is_data && v.we) check16("mem_wdata", mem_wdata, v.wdata);
        data_req = 1'b0; ifetch_req = 1'b0;
        @(negedge clk);  // second ACCESS cycle
        check1("mem_en_c2", mem_en, 1'b1);
        check1("mem_we_c2", mem_we, v.is_data & v.we);
        check1("gnt_c2", data_gnt | ifetch_gnt, 1'b0);
        @(negedge clk);  // DONE
        if (!v.is_data) exp_i = v.exp_rdata;
        else if (!v.we) exp_d = v.exp_rdata;
        check1("mem_en_done", mem_en, 1'b0);
        check1("data_valid", data_valid, v.is_data);
        check1("ifetch_valid", ifetch_valid, !v.is_data);
        check16("data_rdata", data_rdata, exp_d);
        check16("ifetch_rdata", ifetch_rdata, exp_i);
        check1("busy_done", busy, 1'b1);
        @(negedge clk);  // back to IDLE
        check1("busy_idle", busy, 1'b0);
        check1("valid_idle", data_valid | ifetch_valid, 1'b0);
        $display("txn %0d: %s we=%0d addr=%h wdata=%h exp=%h", idx,
                 v.is_data ? "data " : "fetch", v.we, v.addr, v.wdata, v.exp_rdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        string  exp_seq;
        int     g;
        int     cyc;
        logic [7:0] got_ch;

        vecs[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'h1234};
        vecs[1] = '{1'b1, 1'b1, 16'h0040, 16'hBEEF, 16'h0000};
        vecs[2] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 16'hBEEF};
        vecs[3] = '{1'b0, 1'b0, 16'h0020, 16'h0000, 16'h5A5A};
        vecs[4] = '{1'b1, 1'b1, 16'h0041, 16'h0F0F, 16'h0000};
        vecs[5] = '{1'b1, 1'b0, 16'h0041, 16'h0000, 16'h0F0F};
        vecs[6] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'h1234};

        rst = 1'b1;
        ifetch_req = 1'b0; ifetch_addr = '0;
        data_req = 1'b0; data_we = 1'b0; data_addr = '0; data_wdata = '0;
        f1_req = 1'b0; f1_addr = 16'h0010;
        d1_req = 1'b0; d1_we = 1'b0; d1_addr = '0; d1_wdata = '0;
        exp_i = '0; exp_d = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check1("rst_gnt", ifetch_gnt | data_gnt, 1'b0);
        check1("rst_valid", ifetch_valid | data_valid, 1'b0);
        check1("rst_mem_en", mem_en, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check16("rst_data_rdata", data_rdata, 16'h0000);
        check16("rst_ifetch_rdata", ifetch_rdata, 16'h0000);
        check16("rst_mem_addr", mem_addr, 16'h0000);
        rst = 1'b0;

        // Table-driven single transactions
        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Both request together: data first, fetch right after DONE
        @(negedge clk);
        data_req = 1'b1; data_we = 1'b0; data_addr = 16'h0040;
        ifetch_req = 1'b1; ifetch_addr = 16'h0020;
        @(negedge clk);
        check1("both_data_gnt", data_gnt, 1'b1);
        check1("both_fetch_nognt", ifetch_gnt, 1'b0);
        check16("both_mem_addr_d", mem_addr, 16'h0040);
        data_req = 1'b0;
        @(negedge clk);
        check1("both_fetch_wait", ifetch_gnt, 1'b0);
        @(negedge clk);
        check1("both_data_valid", data_valid, 1'b1);
        check16("both_data_rdata", data_rdata, 16'hBEEF);
        check1("both_fetch_wait2", ifetch_gnt, 1'b0);
        @(negedge clk);
        check1("both_fetch_gnt", ifetch_gnt, 1'b1);
        check16("both_mem_addr_f", mem_addr, 16'h0020);
        ifetch_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check1("both_fetch_valid", ifetch_valid, 1'b1);
        check16("both_ifetch_rdata", ifetch_rdata, 16'h5A5A);
        $display("txn both: data then fetch");
        exp_d = 16'hBEEF; exp_i = 16'h5A5A;

        // Both held continuously: starvation guard pattern
        @(negedge clk);
        data_req = 1'b1; data_we = 1'b0; data_addr = 16'h0040;
        ifetch_req = 1'b1; ifetch_addr = 16'h0010;
        exp_seq = "DDDFDDDF";
        g = 0; cyc = 0;
        while (g < 8 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            check1("gnt_onehot", data_gnt & ifetch_gnt, 1'b0);
            check1("valid_onehot", data_valid & ifetch_valid, 1'b0);
            if (data_gnt || ifetch_gnt) begin
                got_ch = data_gnt ? 8'h44 : 8'h46;
                check16($sformatf("grant_seq[%0d]", g), {8'h00, got_ch}, {8'h00, exp_seq[g]});
                g++;
            end
        end
        data_req = 1'b0; ifetch_req = 1'b0;
        n_cmp++;
        if (g < 8) begin
            n_bad++;
            $display("FAIL grant_seq_timeout: got %0d grants required 8", g);
        end
        $display("txn starve: %0d grants in %0d cycles", g, cyc);
        cyc = 0;
        while (busy && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check1("starve_idle", busy, 1'b0);

        // Reset during the second ACCESS cycle of a store
        @(negedge clk);
        data_req = 1'b1; data_we = 1'b1; data_addr = 16'h0050; data_wdata = 16'hAAAA;
        @(negedge clk);
        check1("rststore_gnt", data_gnt, 1'b1);
        data_req = 1'b0;
        @(negedge clk);
        check1("rststore_mem_en", mem_en, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check1("rststore_mem_en0", mem_en, 1'b0);
        check1("rststore_mem_we0", mem_we, 1'b0);
        check16("rststore_mem_addr0", mem_addr, 16'h0000);
        check16("rststore_mem_wdata0", mem_wdata, 16'h0000);
        check1("rststore_busy0", busy, 1'b0);
        check1("rststore_valid0", data_valid | ifetch_valid, 1'b0);
        check16("rststore_data_rdata0", data_rdata, 16'h0000);
        check16("rststore_ifetch_rdata0", ifetch_rdata, 16'h0000);
        repeat (6) begin
            @(negedge clk);
            check1("rststore_no_valid", data_valid, 1'b0);
        end
        $display("txn reset: store aborted");

        // MEM_LATENCY=1: held fetch request gives a valid every 2 cycles
        @(negedge clk);
        f1_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check1("lat1_gnt", f1_gnt, 1'b1);
            check1("lat1_mem_en", mem1_en, 1'b1);
            check1("lat1_valid_early", f1_valid, 1'b0);
            @(negedge clk);
            check1("lat1_valid", f1_valid, 1'b1);
            check1("lat1_gnt_done", f1_gnt, 1'b0);
            check1("lat1_mem_en_done", mem1_en, 1'b0);
            check16("lat1_rdata", f1_rdata, 16'h1234);
            $display("txn lat1 fetch %0d", k);
        end
        f1_req = 1'b0;
        @(negedge clk);
        check1("lat1_idle_gnt", f1_gnt, 1'b0);
        check1("lat1_idle_busy", busy1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
